gmii_tx_framer: RTL
===================

Name: gmii_tx_framer

Overview:
Transmit-side framer. It takes packet bytes from a first-word-fall-through packet buffer and drives a GMII-style transmit interface (tx_en/tx_data/tx_er). The wire format is preamble, then SFD, then payload, with a minimum inter-packet gap enforced between frames. It sits between the packet FIFO read port and the PHY transmit pins, all in one clock domain. A source underrun mid-frame aborts the frame with tx_er instead of emitting a corrupted short frame.

Parameters:
PRE_LEN, 7, number of 0x55 preamble bytes before the SFD (legal range 1..15).
SFD, 8'hD5, start-of-frame delimiter byte.
IFG_LEN, 12, minimum tx_en-low cycles between frames (legal range 1..63).

Ports:
clk  in  1  transmit clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
s_data  in  8  payload byte from the buffer.
s_er  in  1  error flag carried with the byte; copied to tx_er.
s_last  in  1  marks the final byte of a packet.
s_valid  in  1  byte available; may only be held high when a byte is present (FWFT).
s_ready  out  1  byte consumed on a clock where s_valid and s_ready are both high.
tx_data  out  8  GMII transmit data, registered.
tx_en  out  1  GMII transmit enable, registered.
tx_er  out  1  GMII transmit error, registered.
busy  out  1  high in every state except IDLE.
underrun  out  1  one-cycle pulse when a frame is aborted.
frame_cnt  out  16  count of frames completed normally; wraps from 0xFFFF to 0.

Behaviour:
- Reset (synchronous, active-high; clk is the single clock): state=IDLE, tx_en=0, tx_er=0, tx_data=0x00, s_ready=0, busy=0, underrun=0, frame_cnt=0. Reset mid-frame drops tx_en on the next edge with no tx_er. The source is responsible for flushing any partial packet it holds.
- All tx_* outputs are registered. s_ready is a combinational decode of the state: high only in DATA and DRAIN.
- States and transitions:
  - IDLE: tx_en=0. If s_valid is sampled high, go to PRE. tx_data=0x55 and tx_en=1 appear on the same edge.
  - PRE: count PRE_LEN bytes of 0x55 in total. On the edge that ends the final preamble byte, drive SFD and go to DATA.
  - DATA: s_ready=1.
    - s_valid=1: on that edge, tx_data<=s_data, tx_er<=s_er, tx_en<=1. If s_last is also high, go to IFG and increment frame_cnt.
    - s_valid=0 (underrun): on that edge, tx_en<=1, tx_er<=1, tx_data<=0x00, underrun<=1 for one cycle, go to DRAIN.
  - DRAIN: tx_en=0, tx_er=0, s_ready=1. Discard bytes until s_valid&&s_last is accepted, then go to IFG. frame_cnt is not incremented.
  - IFG: tx_en=0. Count IFG_LEN cycles with tx_en low. On completion, if s_valid=1, go straight to PRE, so the gap is exactly IFG_LEN cycles. Otherwise go to IDLE.
- Latency:
  - First preamble byte is on the wire 1 clock after s_valid is sampled in IDLE.
  - Payload byte 0 is accepted on the edge that ends the SFD cycle.
  - Payload is contiguous on the wire at 1 byte per clock, with no holes while s_valid stays high.
- Single-byte packet (s_last on byte 0): legal. The wire carries PRE_LEN+1+1 tx_en-high cycles.
- s_er on a payload byte passes through to tx_er on that byte only. It does not abort the frame.
- Counters are sized with $clog2 of their maximum value. The PRE and IFG counters reset to 0 on every state entry.

Decomposition:
- Shared package holds:
  - state enum: IDLE, PRE, DATA, DRAIN, IFG;
  - constants: GMII_PREAMBLE=8'h55, GMII_SFD=8'hD5.
- Single module. No sub-module is needed: the FSM plus two small counters fit comfortably in one file.

Test Plan:
- Reset, then a 4-byte packet {11,22,33,44}, s_valid held → tx_en high for 12 cycles, wire 55×7, D5, 11, 22, 33, 44; tx_er=0; frame_cnt=1.
- Two packets back to back, s_valid never dropped → tx_en low for exactly 12 cycles between frames; second preamble starts on the 13th cycle.
- Underrun: 3-byte packet whose source drops s_valid after byte 1 → wire D5, b0, b1, then one cycle of tx_en=1/tx_er=1/0x00, then tx_en=0; underrun pulses once; remaining bytes are drained through s_last; frame_cnt is unchanged.
- s_er=1 on byte 2 of 5 → tx_er=1 on exactly that wire cycle; the frame completes and frame_cnt increments.
- rst asserted during the DATA state → tx_en=0, tx_er=0, busy=0 after the next edge; a subsequent packet frames correctly from its preamble.
- Force frame_cnt to 0xFFFF and complete one frame → frame_cnt=0x0000.

Source files
------------

// File: rtl/gmii_tx_framer_pkg.sv
// Shared types and wire constants for the GMII transmit framer.
package gmii_tx_framer_pkg;

    // state | meaning
    // IDLE  | wire quiet, waiting for a packet in the buffer
    // PRE   | preamble bytes on the wire, SFD follows
    // DATA  | payload streaming from the buffer
    // DRAIN | frame aborted, discarding the rest of the packet
    // IFG   | enforcing the minimum inter-packet gap
    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        DRAIN,
        IFG
    } state_t;

    localparam logic [7:0] GMII_PREAMBLE = 8'h55;
    localparam logic [7:0] GMII_SFD      = 8'hD5;

endpackage

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload from a FWFT buffer, then a
// minimum gap. A mid-frame underrun ends the frame with one tx_er cycle.
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int         PRE_LEN = 7,
    parameter logic [7:0] SFD     = GMII_SFD,
    parameter int         IFG_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_er,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        tx_er,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    // The preamble counter only needs to reach PRE_LEN-1; keep at least one bit.
    localparam int PRE_W = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    localparam int IFG_W = $clog2(IFG_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_LEN - 1);
    localparam logic [IFG_W-1:0] IFG_DONE = IFG_W'(IFG_LEN);

    state_t           state, state_nx;
    logic [PRE_W-1:0] pre_cnt, pre_cnt_nx;
    logic [IFG_W-1:0] ifg_cnt, ifg_cnt_nx;
    logic [7:0]       data_nx;
    logic             en_nx, er_nx, underrun_nx, frame_inc;

    assign s_ready = (state == DATA) || (state == DRAIN);
    assign busy    = (state != IDLE);

    // Next-state, counter and next-wire decode.
    always_comb begin
        state_nx    = state;
        pre_cnt_nx  = pre_cnt;
        ifg_cnt_nx  = ifg_cnt;
        data_nx     = 8'h00;
        en_nx       = 1'b0;
        er_nx       = 1'b0;
        underrun_nx = 1'b0;
        frame_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_nx   = PRE;
                    pre_cnt_nx = '0;
                    data_nx    = GMII_PREAMBLE;
                    en_nx      = 1'b1;
                end
            end
            PRE: begin
                en_nx = 1'b1;
                if (pre_cnt == PRE_LAST) begin
                    data_nx  = SFD;
                    state_nx = DATA;
                end else begin
                    data_nx    = GMII_PREAMBLE;
                    pre_cnt_nx = pre_cnt + 1'b1;
                end
            end
            DATA: begin
                en_nx = 1'b1;
                if (s_valid) begin
                    data_nx = s_data;
                    er_nx   = s_er;
                    if (s_last) begin
                        state_nx   = IFG;
                        ifg_cnt_nx = '0;
                        frame_inc  = 1'b1;
                    end
                end else begin
                    // Source ran dry: poison the frame rather than end it short.
                    er_nx       = 1'b1;
                    underrun_nx = 1'b1;
                    state_nx    = DRAIN;
                end
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    state_nx   = IFG;
                    ifg_cnt_nx = '0;
                end
            end
            IFG: begin
                // The first IFG cycle still shows the last byte, so counting to
                // IFG_LEN inclusive yields exactly IFG_LEN low cycles.
                if (ifg_cnt == IFG_DONE) begin
                    if (s_valid) begin
                        state_nx   = PRE;
                        pre_cnt_nx = '0;
                        data_nx    = GMII_PREAMBLE;
                        en_nx      = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    ifg_cnt_nx = ifg_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, counters and registered GMII outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            ifg_cnt   <= '0;
            tx_data   <= 8'h00;
            tx_en     <= 1'b0;
            tx_er     <= 1'b0;
            underrun  <= 1'b0;
            frame_cnt <= 16'h0000;
        end else begin
            state    <= state_nx;
            pre_cnt  <= pre_cnt_nx;
            ifg_cnt  <= ifg_cnt_nx;
            tx_data  <= data_nx;
            tx_en    <= en_nx;
            tx_er    <= er_nx;
            underrun <= underrun_nx;
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 16'h0001;
            end
        end
    end

endmodule
